// File: rtl/m_opqueue_pkg.sv
// m_opqueue_pkg: shared constants for the instruction queue (NOP word, RV32 field positions).
// Revision: 1.0
`default_nettype none

package m_opqueue_pkg;

  localparam logic [31:0] c_NOPWORD     = 32'h0000_0013;
  localparam int          c_TRG_LSB     = 7;
  localparam int          c_FUNC3_LSB   = 12;
  localparam int          c_SRC1_LSB    = 15;
  localparam int          c_SRC2_LSB    = 20;
  localparam int          c_FUNC7_5_BIT = 30;
  localparam int          c_REG_W       = 5;
  localparam int          c_FUNC3_W     = 3;

  // A one-entry queue still needs a one-bit pointer; it is simply held at zero.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_opqueue_ctl.sv
// m_opqueue_ctl: read/write pointers, occupancy count and flush/write/take priority.
// Revision: 1.0
`default_nettype none

module m_opqueue_ctl
  import m_opqueue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = ptr_width(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_flush,
  input  logic          i_wr_valid,
  input  logic          i_rd_take,
  output logic          o_we,
  output logic          o_wr_ready,
  output logic          o_rd_valid,
  output logic [PW-1:0] o_wptr,
  output logic [PW-1:0] o_rptr,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_write;
  logic          w_take;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  // wr_ready depends only on registered count, so there is no path from rd_take.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_write = i_wr_valid & ~w_full;
  assign w_take  = i_rd_take & ~w_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) r_wptr <= f_inc(r_wptr);
      if (w_take)  r_rptr <= f_inc(r_rptr);
      if (w_write && !w_take)
        r_count <= r_count + CW'(1);
      else if (w_take && !w_write)
        r_count <= r_count - CW'(1);
    end
  end

  assign o_we       = w_write & ~i_flush;
  assign o_wr_ready = ~w_full;
  assign o_rd_valid = ~w_empty;
  assign o_wptr     = r_wptr;
  assign o_rptr     = r_rptr;
  assign o_count    = r_count;

endmodule

`default_nettype wire

// File: rtl/m_opqueue.sv
// m_opqueue: DEPTH-entry instruction queue between fetch data (Di) and decode.
// Revision: 1.0
`default_nettype none

module m_opqueue
  import m_opqueue_pkg::*;
#(
  parameter int              DEPTH     = 2,
  parameter int              XLEN      = 32,
  parameter int              HIGHLEVEL = 1,
  parameter logic [XLEN-1:0] NOPWORD   = XLEN'(c_NOPWORD)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [XLEN-1:0]              Di,
  output logic                         rd_valid,
  input  logic                         rd_take,
  output logic [XLEN-1:0]              INSTR,
  output logic [c_REG_W-1:0]           TRG,
  output logic [c_REG_W-1:0]           SRC1,
  output logic [c_REG_W-1:0]           SRC2,
  output logic [c_FUNC3_W-1:0]         FUNC3,
  output logic                         FUNC7_5,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW    = ptr_width(DEPTH);
  localparam int NSLOT = 1 << PW;

  logic            w_we;
  logic [PW-1:0]   w_wptr;
  logic [PW-1:0]   w_rptr;
  logic [XLEN-1:0] w_mem [NSLOT];
  logic [XLEN-1:0] w_head;

  m_opqueue_ctl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    ($clog2(DEPTH + 1))
  ) u_ctl (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (flush),
    .i_wr_valid (wr_valid),
    .i_rd_take  (rd_take),
    .o_we       (w_we),
    .o_wr_ready (wr_ready),
    .o_rd_valid (rd_valid),
    .o_wptr     (w_wptr),
    .o_rptr     (w_rptr),
    .o_count    (count)
  );

  generate
    if (HIGHLEVEL != 0) begin : g_behav
      logic [XLEN-1:0] r_mem [NSLOT];
      always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wptr] <= Di;
      end
      assign w_mem = r_mem;
    end else begin : g_prim
      // One enable+reset register bank per slot, matching a DFFER-per-bit mapping.
      for (genvar i = 0; i < NSLOT; i++) begin : g_entry
        logic [XLEN-1:0] r_word;
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn)
            r_word <= '0;
          else if (w_we && (w_wptr == PW'(i)))
            r_word <= Di;
        end
        assign w_mem[i] = r_word;
      end
    end
  endgenerate

  assign w_head  = w_mem[w_rptr];
  assign INSTR   = rd_valid ? w_head : NOPWORD;
  assign TRG     = INSTR[c_TRG_LSB  +: c_REG_W];
  assign SRC1    = INSTR[c_SRC1_LSB +: c_REG_W];
  assign SRC2    = INSTR[c_SRC2_LSB +: c_REG_W];
  assign FUNC3   = INSTR[c_FUNC3_LSB +: c_FUNC3_W];
  assign FUNC7_5 = INSTR[c_FUNC7_5_BIT];

endmodule

`default_nettype wire

// File: tb/tb_m_opqueue.sv
// tb_m_opqueue: three queue configurations (D2/behavioural, D4/primitive, D1/behavioural) on shared stimulus.
// Revision: 1.0
`default_nettype none

module tb_m_opqueue;

  localparam int          N   = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        rd_take = 1'b0;
  logic [31:0] di = '0;

  logic        wrr [N];
  logic        rdv [N];
  logic [31:0] ins [N];
  logic [4:0]  trg [N];
  logic [4:0]  s1  [N];
  logic [4:0]  s2  [N];
  logic [2:0]  f3  [N];
  logic        f7  [N];
  logic [1:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [0:0]  cnt_c;
  logic [3:0]  cnt [N];

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] qc[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign cnt[0] = {2'b00, cnt_a};
  assign cnt[1] = {1'b0, cnt_b};
  assign cnt[2] = {3'b000, cnt_c};

  m_opqueue #(.DEPTH(2), .XLEN(32), .HIGHLEVEL(1), .NOPWORD(32'h13)) u_a (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_valid(wr_valid), .wr_ready(wrr[0]),
    .Di(di), .rd_valid(rdv[0]), .rd_take(rd_take), .INSTR(ins[0]), .TRG(trg[0]),
    .SRC1(s1[0]), .SRC2(s2[0]), .FUNC3(f3[0]), .FUNC7_5(f7[0]), .count(cnt_a));

  m_opqueue #(.DEPTH(4), .XLEN(32), .HIGHLEVEL(0), .NOPWORD(32'h13)) u_b (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_valid(wr_valid), .wr_ready(wrr[1]),
    .Di(di), .rd_valid(rdv[1]), .rd_take(rd_take), .INSTR(ins[1]), .TRG(trg[1]),
    .SRC1(s1[1]), .SRC2(s2[1]), .FUNC3(f3[1]), .FUNC7_5(f7[1]), .count(cnt_b));

  m_opqueue #(.DEPTH(1), .XLEN(32), .HIGHLEVEL(1), .NOPWORD(32'h13)) u_c (
    .clk(clk), .rstn(rstn), .flush(flush), .wr_valid(wr_valid), .wr_ready(wrr[2]),
    .Di(di), .rd_valid(rdv[2]), .rd_take(rd_take), .INSTR(ins[2]), .TRG(trg[2]),
    .SRC1(s1[2]), .SRC2(s2[2]), .FUNC3(f3[2]), .FUNC7_5(f7[2]), .count(cnt_c));

  // ---------------- reference model: one plain FIFO queue per configuration
  function automatic int dep(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [31:0] exp_head(input int k);
    if (qsize(k) == 0) return NOP;
    case (k)
      0:       return qa[0];
      1:       return qb[0];
      default: return qc[0];
    endcase
  endfunction

  task automatic mclear();
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  task automatic mpop(input int k);
    case (k)
      0:       void'(qa.pop_front());
      1:       void'(qb.pop_front());
      default: void'(qc.pop_front());
    endcase
  endtask

  task automatic mpush(input int k, input logic [31:0] d);
    case (k)
      0:       qa.push_back(d);
      1:       qb.push_back(d);
      default: qc.push_back(d);
    endcase
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
  task automatic step(input logic f, input logic wv, input logic [31:0] d, input logic t);
    int sz;
    flush = f; wr_valid = wv; di = d; rd_take = t;
    @(posedge clk);
    if (!rstn || f) begin
      mclear();
    end else begin
      for (int k = 0; k < N; k++) begin
        sz = qsize(k);
        if (t && sz != 0) mpop(k);
        if (wv && sz != dep(k)) mpush(k, d);
      end
    end
    #1;
    flush = 1'b0; wr_valid = 1'b0; rd_take = 1'b0;
  endtask

  // ---------------- tests
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    mclear();
    for (int k = 0; k < N; k++) begin
      n_tests++; if (cnt[k] !== 4'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", k, cnt[k]); end
      n_tests++; if (rdv[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid[%0d] got %b want 0", k, rdv[k]); end
      n_tests++; if (wrr[k] !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready[%0d] got %b want 1", k, wrr[k]); end
      n_tests++; if (ins[k] !== NOP) begin n_fail++; $display("FAIL reset_instr[%0d] got %h want %h", k, ins[k], NOP); end
      n_tests++; if (trg[k] !== 5'd0) begin n_fail++; $display("FAIL reset_trg[%0d] got %0d want 0", k, trg[k]); end
    end
  endtask

  task automatic test_single();
    logic [31:0] got [8];
    logic [31:0] want [8];
    string       nm [8];
    step(1'b0, 1'b1, 32'h00B50533, 1'b0);
    got[0] = {31'd0, rdv[0]}; want[0] = 32'd1;          nm[0] = "single_rd_valid";
    got[1] = ins[0];          want[1] = 32'h00B50533;   nm[1] = "single_instr";
    got[2] = {27'd0, trg[0]}; want[2] = 32'd10;         nm[2] = "single_trg";
    got[3] = {27'd0, s1[0]};  want[3] = 32'd10;         nm[3] = "single_src1";
    got[4] = {27'd0, s2[0]};  want[4] = 32'd11;         nm[4] = "single_src2";
    got[5] = {29'd0, f3[0]};  want[5] = 32'd0;          nm[5] = "single_func3";
    got[6] = {31'd0, f7[0]};  want[6] = 32'd0;          nm[6] = "single_func7_5";
    got[7] = {28'd0, cnt[0]}; want[7] = 32'd1;          nm[7] = "single_count";
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL %s got %h want %h", nm[i], got[i], want[i]); end
    end
  endtask

  task automatic test_fill_overflow();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40B50533, 1'b0);
    step(1'b0, 1'b1, 32'h00000093, 1'b0);
    n_tests++; if (cnt[0] !== 4'd2) begin n_fail++; $display("FAIL fill_count_d2 got %0d want 2", cnt[0]); end
    n_tests++; if (wrr[0] !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready_d2 got %b want 0", wrr[0]); end
    n_tests++; if (cnt[1] !== 4'd2 || wrr[1] !== 1'b1) begin n_fail++; $display("FAIL fill_d4 got cnt=%0d rdy=%b want cnt=2 rdy=1", cnt[1], wrr[1]); end
    n_tests++; if (cnt[2] !== 4'd1 || wrr[2] !== 1'b0) begin n_fail++; $display("FAIL fill_d1 got cnt=%0d rdy=%b want cnt=1 rdy=0", cnt[2], wrr[2]); end
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    n_tests++; if (cnt[0] !== 4'd2 || ins[0] !== 32'h40B50533) begin n_fail++; $display("FAIL overflow_d2 got cnt=%0d instr=%h want cnt=2 instr=40b50533", cnt[0], ins[0]); end
    n_tests++; if (f7[0] !== 1'b1) begin n_fail++; $display("FAIL overflow_func7_5 got %b want 1", f7[0]); end
    n_tests++; if (cnt[1] !== 4'd3) begin n_fail++; $display("FAIL overflow_d4_count got %0d want 3", cnt[1]); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (ins[0] !== 32'h00000093 || cnt[0] !== 4'd1) begin n_fail++; $display("FAIL take1_d2 got instr=%h cnt=%0d want 00000093 cnt=1", ins[0], cnt[0]); end
    n_tests++; if (rdv[2] !== 1'b0 || ins[2] !== NOP) begin n_fail++; $display("FAIL take1_d1 got valid=%b instr=%h want 0 %h", rdv[2], ins[2], NOP); end
    step(1'b0, 1'b0, 32'h0, 1'b1);
    n_tests++; if (rdv[0] !== 1'b0 || ins[0] !== NOP || cnt[0] !== 4'd0) begin n_fail++; $display("FAIL take2_d2 got valid=%b instr=%h cnt=%0d want 0 %h 0", rdv[0], ins[0], cnt[0], NOP); end
    n_tests++; if (ins[1] !== 32'hDEADBEEF || cnt[1] !== 4'd1) begin n_fail++; $display("FAIL take2_d4 got instr=%h cnt=%0d want deadbeef 1", ins[1], cnt[1]); end
    n_tests++; if (cnt[2] !== 4'd0) begin n_fail++; $display("FAIL take2_d1_count got %0d want 0", cnt[2]); end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h00100093, 1'b0);
    step(1'b0, 1'b1, 32'h00208113, 1'b1);
    n_tests++; if (cnt[0] !== 4'd1 || ins[0] !== 32'h00208113) begin n_fail++; $display("FAIL simul_d2 got cnt=%0d instr=%h want 1 00208113", cnt[0], ins[0]); end
    n_tests++; if (cnt[1] !== 4'd1 || ins[1] !== 32'h00208113) begin n_fail++; $display("FAIL simul_d4 got cnt=%0d instr=%h want 1 00208113", cnt[1], ins[1]); end
    n_tests++; if (cnt[2] !== 4'd0 || ins[2] !== NOP) begin n_fail++; $display("FAIL simul_d1 got cnt=%0d instr=%h want 0 %h", cnt[2], ins[2], NOP); end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h00100093, 1'b0);
    step(1'b0, 1'b1, 32'h00200113, 1'b0);
    step(1'b1, 1'b1, 32'h00300193, 1'b1);
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (cnt[k] !== 4'd0 || rdv[k] !== 1'b0 || ins[k] !== NOP) begin
        n_fail++; $display("FAIL flush[%0d] got cnt=%0d valid=%b instr=%h want 0 0 %h", k, cnt[k], rdv[k], ins[k], NOP);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (rdv[0] !== 1'b0 || ins[0] !== NOP) begin n_fail++; $display("FAIL flush_word_absent got valid=%b instr=%h want 0 %h", rdv[0], ins[0], NOP); end
  endtask

  task automatic test_random();
    logic        f, wv, t;
    logic [31:0] d, e;
    for (int c = 0; c < 300; c++) begin
      f  = ($urandom_range(0, 19) == 0);
      wv = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 2) != 0);
      d  = $urandom;
      step(f, wv, d, t);
      for (int k = 0; k < N; k++) begin
        e = exp_head(k);
        n_tests++;
        if (ins[k] !== e || rdv[k] !== (qsize(k) != 0) || wrr[k] !== (qsize(k) != dep(k)) ||
            cnt[k] !== 4'(qsize(k)) || trg[k] !== e[11:7] || s2[k] !== e[24:20]) begin
          n_fail++;
          $display("FAIL random[%0d] cyc %0d got instr=%h v=%b r=%b cnt=%0d want instr=%h cnt=%0d",
                   k, c, ins[k], rdv[k], wrr[k], cnt[k], e, qsize(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h00B50533, 1'b0);
    step(1'b0, 1'b1, 32'h40B50533, 1'b0);
    n_tests++; if (cnt[0] !== 4'd2) begin n_fail++; $display("FAIL async_pre_count got %0d want 2", cnt[0]); end
    #3 rstn = 1'b0;
    #1;
    mclear();
    for (int k = 0; k < N; k++) begin
      n_tests++;
      if (cnt[k] !== 4'd0 || rdv[k] !== 1'b0 || wrr[k] !== 1'b1 || ins[k] !== NOP) begin
        n_fail++; $display("FAIL async_reset[%0d] got cnt=%0d valid=%b rdy=%b instr=%h want 0 0 1 %h", k, cnt[k], rdv[k], wrr[k], ins[k], NOP);
      end
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n_tests++; if (cnt[1] !== 4'd0 || ins[1] !== NOP) begin n_fail++; $display("FAIL async_post_d4 got cnt=%0d instr=%h want 0 %h", cnt[1], ins[1], NOP); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
